fetch_decode_unit: RTL and testbench

//  Fetch/decode stage that feeds control_unit: holds the program counter (PC) and the instruction register (IR).

---
 rtl/k_and_s_pkg.sv | 51 +++++
 rtl/instr_decoder.sv | 66 ++++++
 rtl/fetch_decode_unit.sv | 72 +++++++
 tb/tb_fetch_decode_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the fetch/decode stage: decoded instruction
// enum, opcode values and register-field bit positions inside the IR.
package k_and_s_pkg;

  localparam int OPCODE_W = 8;
  localparam int REG_W    = 2;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_BRANCH = 4'd1,
    I_BZERO  = 4'd2,
    I_BNZERO = 4'd3,
    I_BNEG   = 4'd4,
    I_BNNEG  = 4'd5,
    I_BOV    = 4'd6,
    I_BNOV   = 4'd7,
    I_LOAD   = 4'd8,
    I_STORE  = 4'd9,
    I_MOVE   = 4'd10,
    I_ADD    = 4'd11,
    I_SUB    = 4'd12,
    I_AND    = 4'd13,
    I_OR     = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  localparam logic [7:0] OPC_BRANCH = 8'h00;
  localparam logic [7:0] OPC_BZERO  = 8'h01;
  localparam logic [7:0] OPC_BNZERO = 8'h09;
  localparam logic [7:0] OPC_BNEG   = 8'h02;
  localparam logic [7:0] OPC_BNNEG  = 8'h0A;
  localparam logic [7:0] OPC_BOV    = 8'h03;
  localparam logic [7:0] OPC_BNOV   = 8'h0B;
  localparam logic [7:0] OPC_LOAD   = 8'h81;
  localparam logic [7:0] OPC_STORE  = 8'h82;
  localparam logic [7:0] OPC_MOVE   = 8'h91;
  localparam logic [7:0] OPC_ADD    = 8'hA1;
  localparam logic [7:0] OPC_SUB    = 8'hA2;
  localparam logic [7:0] OPC_AND    = 8'hA3;
  localparam logic [7:0] OPC_OR     = 8'hA4;
  localparam logic [7:0] OPC_HALT   = 8'hFF;

  // LSB positions of the 2-bit register fields for each instruction format
  localparam int ALU_C_LSB  = 4;
  localparam int ALU_A_LSB  = 2;
  localparam int ALU_B_LSB  = 0;
  localparam int MOVE_C_LSB = 2;
  localparam int MOVE_A_LSB = 0;
  localparam int MEM_R_LSB  = 5;

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational decode of the instruction register into the control-unit
// instruction code and register-file addresses.
module instr_decoder
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]      ir,
  input  logic                   ir_valid,
  output decoded_instruction_type decoded_instruction,
  output logic [REG_W-1:0]       a_addr,
  output logic [REG_W-1:0]       b_addr,
  output logic [REG_W-1:0]       c_addr
);

  logic [OPCODE_W-1:0] opcode;
  assign opcode = ir[DATA_W-1 -: OPCODE_W];

  // Opcode lookup and field extraction; an empty IR decodes as NOP
  always_comb begin
    decoded_instruction = I_NOP;
    a_addr = 2'd0;
    b_addr = 2'd0;
    c_addr = 2'd0;
    if (ir_valid) begin
      case (opcode)
        OPC_BRANCH: decoded_instruction = I_BRANCH;
        OPC_BZERO:  decoded_instruction = I_BZERO;
        OPC_BNZERO: decoded_instruction = I_BNZERO;
        OPC_BNEG:   decoded_instruction = I_BNEG;
        OPC_BNNEG:  decoded_instruction = I_BNNEG;
        OPC_BOV:    decoded_instruction = I_BOV;
        OPC_BNOV:   decoded_instruction = I_BNOV;
        OPC_HALT:   decoded_instruction = I_HALT;
        OPC_LOAD: begin
          decoded_instruction = I_LOAD;
          c_addr = ir[MEM_R_LSB +: REG_W];
        end
        OPC_STORE: begin
          decoded_instruction = I_STORE;
          a_addr = ir[MEM_R_LSB +: REG_W];
        end
        OPC_MOVE: begin
          decoded_instruction = I_MOVE;
          c_addr = ir[MOVE_C_LSB +: REG_W];
          a_addr = ir[MOVE_A_LSB +: REG_W];
        end
        OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
          case (opcode)
            OPC_ADD: decoded_instruction = I_ADD;
            OPC_SUB: decoded_instruction = I_SUB;
            OPC_AND: decoded_instruction = I_AND;
            default: decoded_instruction = I_OR;
          endcase
          c_addr = ir[ALU_C_LSB +: REG_W];
          a_addr = ir[ALU_A_LSB +: REG_W];
          b_addr = ir[ALU_B_LSB +: REG_W];
        end
        default: decoded_instruction = I_NOP;
      endcase
    end else begin
      decoded_instruction = I_NOP;
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: PC and IR registers, RAM address select, retired-fetch
// counter, and the instruction decoder feeding the control unit.
module fetch_decode_unit
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    branch,
  input  logic                    addr_sel,
  input  logic                    halt,
  input  logic [DATA_W-1:0]       ram_data_out,
  output logic [ADDR_W-1:0]       ram_addr,
  output decoded_instruction_type decoded_instruction,
  output logic [REG_W-1:0]        a_addr,
  output logic [REG_W-1:0]        b_addr,
  output logic [REG_W-1:0]        c_addr,
  output logic [ADDR_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       ir_out,
  output logic [CNT_W-1:0]        instr_count
);

  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] ir_r;
  logic              ir_valid_r;
  logic [CNT_W-1:0]  count_r;

  // PC/IR/counter update; all next values come from pre-edge state, and halt freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= {ADDR_W{1'b0}};
      ir_r       <= {DATA_W{1'b0}};
      ir_valid_r <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
    end else if (!halt) begin
      if (ir_enable) begin
        ir_r       <= ram_data_out;
        ir_valid_r <= 1'b1;
        if (count_r != {CNT_W{1'b1}}) begin
          count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      if (pc_enable) begin
        if (branch) begin
          pc_r <= ir_r[ADDR_W-1:0];
        end else begin
          pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign ram_addr    = addr_sel ? ir_r[ADDR_W-1:0] : pc_r;
  assign pc_out      = pc_r;
  assign ir_out      = ir_r;
  assign instr_count = count_r;

  instr_decoder #(.DATA_W(DATA_W)) u_decoder (
    .ir                  (ir_r),
    .ir_valid            (ir_valid_r),
    .decoded_instruction (decoded_instruction),
    .a_addr              (a_addr),
    .b_addr              (b_addr),
    .c_addr              (c_addr)
  );

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed + randomized bench for fetch_decode_unit against a behavioural model.
module tb_fetch_decode_unit;
  import k_and_s_pkg::*;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0, branch = 1'b0;
  logic addr_sel = 1'b0, halt = 1'b0;
  logic [15:0] ram_data_out = 16'h0000;
  logic [4:0]  ram_addr, pc_out;
  decoded_instruction_type decoded_instruction;
  logic [1:0]  a_addr, b_addr, c_addr;
  logic [15:0] ir_out;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_pc = 0, m_ir = 0, m_valid = 0, m_cnt = 0;
  decoded_instruction_type dec_tbl [int];

  always #5 clk = ~clk;

  fetch_decode_unit #(.DATA_W(16), .ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .branch(branch), .addr_sel(addr_sel), .halt(halt), .ram_data_out(ram_data_out),
    .ram_addr(ram_addr), .decoded_instruction(decoded_instruction),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .pc_out(pc_out), .ir_out(ir_out), .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic decoded_instruction_type exp_dec();
    int op;
    op = (m_ir >> 8) & 255;
    if (m_valid == 0) return I_NOP;
    if (dec_tbl.exists(op)) return dec_tbl[op];
    return I_NOP;
  endfunction

  function automatic bit is_alu(decoded_instruction_type d);
    return (d == I_ADD) || (d == I_SUB) || (d == I_AND) || (d == I_OR);
  endfunction

  task automatic check_all(input string tag);
    decoded_instruction_type d;
    int ea, eb, ec;
    d = exp_dec();
    ea = 0; eb = 0; ec = 0;
    if (is_alu(d)) begin
      ec = (m_ir >> 4) & 3; ea = (m_ir >> 2) & 3; eb = m_ir & 3;
    end else if (d == I_MOVE) begin
      ec = (m_ir >> 2) & 3; ea = m_ir & 3;
    end else if (d == I_LOAD) begin
      ec = (m_ir >> 5) & 3;
    end else if (d == I_STORE) begin
      ea = (m_ir >> 5) & 3;
    end
    check({tag, "_pc"}, 32'(pc_out), 32'(m_pc));
    check({tag, "_ir"}, 32'(ir_out), 32'(m_ir));
    check({tag, "_cnt"}, 32'(instr_count), 32'(m_cnt));
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr_sel ? (m_ir % 32) : m_pc));
    check({tag, "_dec"}, 32'(decoded_instruction), 32'(d));
    check({tag, "_a"}, 32'(a_addr), 32'(ea));
    check({tag, "_b"}, 32'(b_addr), 32'(eb));
    check({tag, "_c"}, 32'(c_addr), 32'(ec));
  endtask

  // one clock: model computes next state from pre-edge inputs/state, then compare
  task automatic step(input string tag);
    int n_pc, n_ir, n_valid, n_cnt;
    n_pc = m_pc; n_ir = m_ir; n_valid = m_valid; n_cnt = m_cnt;
    if (rst) begin
      n_pc = 0; n_ir = 0; n_valid = 0; n_cnt = 0;
    end else if (!halt) begin
      if (ir_enable) begin
        n_ir = ram_data_out; n_valid = 1;
        n_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
      if (pc_enable) n_pc = branch ? (m_ir % 32) : ((m_pc + 1) % 32);
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_valid = n_valid; m_cnt = n_cnt;
    check_all(tag);
  endtask

  task automatic set_in(input logic r, pe, ie, br, as, h, input logic [15:0] d);
    rst = r; pc_enable = pe; ir_enable = ie; branch = br; addr_sel = as; halt = h;
    ram_data_out = d;
  endtask

  initial begin
    int known;
    int ops[15];
    dec_tbl[8'h00] = I_BRANCH; dec_tbl[8'h01] = I_BZERO; dec_tbl[8'h09] = I_BNZERO;
    dec_tbl[8'h02] = I_BNEG;   dec_tbl[8'h0A] = I_BNNEG; dec_tbl[8'h03] = I_BOV;
    dec_tbl[8'h0B] = I_BNOV;   dec_tbl[8'h81] = I_LOAD;  dec_tbl[8'h82] = I_STORE;
    dec_tbl[8'h91] = I_MOVE;   dec_tbl[8'hA1] = I_ADD;   dec_tbl[8'hA2] = I_SUB;
    dec_tbl[8'hA3] = I_AND;    dec_tbl[8'hA4] = I_OR;    dec_tbl[8'hFF] = I_HALT;
    ops = '{8'h00, 8'h01, 8'h09, 8'h02, 8'h0A, 8'h03, 8'h0B, 8'h81,
            8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};

    // 1: reset
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step("rst1");
    step("rst2");
    check("t1_pc", 32'(pc_out), 32'd0);
    check("t1_dec", 32'(decoded_instruction), 32'(I_NOP));
    check("t1_ram_addr", 32'(ram_addr), 32'd0);
    check("t1_cnt", 32'(instr_count), 32'd0);

    // 2: fetch ADD with simultaneous PC increment
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA11B);
    step("t2");
    check("t2_ir", 32'(ir_out), 32'h0000A11B);
    check("t2_pc", 32'(pc_out), 32'd1);
    check("t2_dec", 32'(decoded_instruction), 32'(I_ADD));
    check("t2_cab", 32'({c_addr, a_addr, b_addr}), 32'(6'b01_10_11));
    check("t2_cnt", 32'(instr_count), 32'd1);

    // 3: PC wrap 31 -> 0
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 30; i++) step("t3_inc");
    check("t3_pc31", 32'(pc_out), 32'd31);
    step("t3_wrap");
    check("t3_pc0", 32'(pc_out), 32'd0);

    // 4: BRANCH target via addr_sel and branch
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0014);
    step("t4_load");
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    check("t4_ram_addr", 32'(ram_addr), 32'd20);
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step("t4_branch");
    check("t4_pc", 32'(pc_out), 32'd20);
    check("t4_dec", 32'(decoded_instruction), 32'(I_BRANCH));

    // 5: halt overrides strobes; reset overrides halt
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 3; i++) step("t5_halt");
    check("t5_pc", 32'(pc_out), 32'd20);
    check("t5_ir", 32'(ir_out), 32'h00000014);
    check("t5_cnt", 32'(instr_count), 32'd2);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    step("t5_rst");
    check("t5_rst_pc", 32'(pc_out), 32'd0);
    check("t5_rst_dec", 32'(decoded_instruction), 32'(I_NOP));

    // 6: opcode sweep
    known = 0;
    for (int op = 0; op < 256; op++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {op[7:0], 8'($urandom_range(0, 255))});
      step("t6_sweep");
      if (decoded_instruction != I_NOP) known++;
    end
    check("t6_known", 32'(known), 32'd15);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8145);
    step("t6_load");
    check("t6_load_c", 32'(c_addr), 32'd2);
    check("t6_cnt_sat", 32'(instr_count), 32'(CNT_MAX));

    // 7: randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 1) w[15:8] = 8'(ops[$urandom_range(0, 14)]);
      set_in(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 7) == 0), w);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
